// File: rtl/coherence_controller_pkg.sv
// Shared types and constants for the dual-core coherence/bus controller.
package coherence_controller_pkg;

    localparam int unsigned CC_WORD_W = 32;

    // RAM handshake status as reported by the memory model.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DWRITE = 3'd2,
        SNOOP  = 3'd3,
        RAMRD1 = 3'd4,
        RAMRD2 = 3'd5,
        C2C1   = 3'd6,
        C2C2   = 3'd7
    } cc_state_t;

    // Byte offsets of the two words in a dcache block.
    localparam logic [2:0] BLK_W0_OFF = 3'b000;
    localparam logic [2:0] BLK_W1_OFF = 3'b100;

    // Transaction latched at grant time: address, BusRdX intent, owning core.
    typedef struct packed {
        logic [CC_WORD_W-1:0] addr;
        logic                 rdx;
        logic                 cur;
    } txn_t;

    // Word address inside the block containing a.
    function automatic logic [CC_WORD_W-1:0] blk_word(input logic [CC_WORD_W-1:0] a,
                                                      input logic [2:0]           off);
        return {a[CC_WORD_W-1:3], off};
    endfunction

endpackage

// File: rtl/coherence_controller_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer advances only on completion.
module rr_arbiter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt_valid_c,
    output logic       gnt_idx_c
);

    logic last_q;
    logic last_d;

    // Grant the core that was not served last, otherwise the sole requester.
    always_comb begin
        last_d      = upd ? upd_idx : last_q;
        gnt_valid_c = |req;
        gnt_idx_c   = req[~last_q] ? ~last_q : last_q;
    end

    // Pointer register; resets to 1 so core 0 wins the first tie.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/coherence_controller.sv
// Dual-core shared RAM port controller with MSI snoop sequencing.
module coherence_controller
    import coherence_controller_pkg::*;
#(
    parameter int unsigned CPUS   = 2,
    parameter int unsigned WORD_W = CC_WORD_W
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [CPUS-1:0]             iREN,
    input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]             iwait,
    output logic [CPUS-1:0][WORD_W-1:0] iload,
    input  logic [CPUS-1:0]             dREN,
    input  logic [CPUS-1:0]             dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0] daddr,
    input  logic [CPUS-1:0][WORD_W-1:0] dstore,
    output logic [CPUS-1:0]             dwait,
    output logic [CPUS-1:0][WORD_W-1:0] dload,
    input  logic [CPUS-1:0]             cctrans,
    input  logic [CPUS-1:0]             ccwrite,
    output logic [CPUS-1:0]             ccwait,
    output logic [CPUS-1:0]             ccinv,
    output logic [CPUS-1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [WORD_W-1:0]           ramaddr,
    output logic [WORD_W-1:0]           ramstore,
    input  logic [WORD_W-1:0]           ramload,
    input  ramstate_t                   ramstate
);

    cc_state_t       state_q, state_d;
    txn_t            txn_q, txn_d;
    logic [CPUS-1:0] ren_req, arb_req;
    logic            is_wen, is_ren;
    logic            arb_valid, arb_idx, arb_upd;
    logic            acc, cur_idx, oth_idx, w1;

    assign acc     = (ramstate == ACCESS);
    assign cur_idx = txn_q.cur;
    assign oth_idx = ~txn_q.cur;
    assign w1      = (state_q == RAMRD2) || (state_q == C2C2);

    // Priority class select: write-backs, then snooping reads, then fetches.
    always_comb begin
        ren_req = dREN & cctrans;
        is_wen  = |dWEN;
        is_ren  = !is_wen && (|ren_req);
        arb_req = is_wen ? dWEN : (is_ren ? ren_req : iREN);
    end

    rr_arbiter u_arb (
        .CLK        (CLK),
        .nRST       (nRST),
        .req        (arb_req),
        .upd        (arb_upd),
        .upd_idx    (cur_idx),
        .gnt_valid_c(arb_valid),
        .gnt_idx_c  (arb_idx)
    );

    // Next-state and Moore outputs; wait/load lines follow ramstate directly.
    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        arb_upd     = 1'b0;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        // Other core is held in snoop from SNOOP entry to the final access.
        if (state_q inside {SNOOP, RAMRD1, RAMRD2, C2C1, C2C2}) begin
            ccwait[oth_idx]      = 1'b1;
            ccinv[oth_idx]       = txn_q.rdx;
            ccsnoopaddr[oth_idx] = txn_q.addr;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    txn_d.cur = arb_idx;
                    txn_d.rdx = 1'b0;
                    if (is_wen) begin
                        txn_d.addr = daddr[arb_idx];
                        state_d    = DWRITE;
                    end else if (is_ren) begin
                        txn_d.addr = daddr[arb_idx];
                        txn_d.rdx  = ccwrite[arb_idx];
                        state_d    = SNOOP;
                    end else begin
                        txn_d.addr = iaddr[arb_idx];
                        state_d    = IFETCH;
                    end
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = txn_q.addr;
                if (acc) begin
                    iwait[cur_idx] = 1'b0;
                    iload[cur_idx] = ramload;
                    arb_upd        = 1'b1;
                    state_d        = IDLE;
                end
            end
            DWRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = txn_q.addr;
                ramstore = dstore[cur_idx];
                if (acc) begin
                    dwait[cur_idx] = 1'b0;
                    arb_upd        = 1'b1;
                    state_d        = IDLE;
                end
            end
            SNOOP: begin
                if (cctrans[oth_idx]) begin
                    state_d = ccwrite[oth_idx] ? C2C1 : RAMRD1;
                end
            end
            RAMRD1, RAMRD2: begin
                ramREN  = 1'b1;
                ramaddr = blk_word(txn_q.addr, w1 ? BLK_W1_OFF : BLK_W0_OFF);
                if (acc) begin
                    dload[cur_idx] = ramload;
                    dwait[cur_idx] = 1'b0;
                    arb_upd        = w1;
                    state_d        = w1 ? IDLE : RAMRD2;
                end
            end
            C2C1, C2C2: begin
                ramWEN   = 1'b1;
                ramaddr  = blk_word(txn_q.addr, w1 ? BLK_W1_OFF : BLK_W0_OFF);
                ramstore = dstore[oth_idx];
                if (acc) begin
                    dload[cur_idx] = dstore[oth_idx];
                    dwait[cur_idx] = 1'b0;
                    dwait[oth_idx] = 1'b0;
                    arb_upd        = w1;
                    state_d        = w1 ? IDLE : C2C2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction; reset drops any transaction in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
        end
    end

endmodule

// File: tb/tb_coherence_controller.sv
// Directed vector bench for coherence_controller with a latency-programmable RAM model.
module tb_coherence_controller;
    import coherence_controller_pkg::*;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    int               n_vec = 0;
    int               n_miscmp = 0;
    int unsigned      lat = 0;
    int unsigned      cnt = 0;
    logic [31:0]      mem [0:255];
    bit               mem_init = 1'b0;

    coherence_controller dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM model: ACCESS after `lat` BUSY cycles of a held strobe; word i holds A000_0000 + 4*i.
    always_comb begin
        if (ramREN || ramWEN) ramstate = (cnt >= lat) ? ACCESS : BUSY;
        else                  ramstate = FREE;
    end
    assign ramload = mem[ramaddr[9:2]];

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i * 4);
            mem_init <= 1'b1;
        end else if ((ramREN || ramWEN) && ramstate == ACCESS && ramWEN) begin
            mem[ramaddr[9:2]] <= ramstore;
        end
        if ((ramREN || ramWEN) && ramstate != ACCESS) cnt <= cnt + 1;
        else                                          cnt <= 0;
    end

    typedef struct {
        logic        rst_n;
        int unsigned lat;
        logic [1:0]  iren, dren, dwen, cct, ccw;
        logic [1:0]  e_iwait, e_dwait, e_ccwait, e_ccinv;
        logic        e_ren, e_wen;
        logic [31:0] e_raddr, e_rstore;
        logic [63:0] e_iload, e_dload, e_snoop;
    } vec_t;

    localparam logic [63:0] Z = 64'h0;

    function automatic vec_t mk(input logic rst_n, input int unsigned l,
                                input logic [1:0] iren, dren, dwen, cct, ccw,
                                input logic [1:0] iw, dw, ccwt, cci,
                                input logic ren, wen, input logic [31:0] ra, rs,
                                input logic [63:0] il, dl, sn);
        vec_t v;
        v.rst_n = rst_n; v.lat = l;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.cct = cct; v.ccw = ccw;
        v.e_iwait = iw; v.e_dwait = dw; v.e_ccwait = ccwt; v.e_ccinv = cci;
        v.e_ren = ren; v.e_wen = wen; v.e_raddr = ra; v.e_rstore = rs;
        v.e_iload = il; v.e_dload = dl; v.e_snoop = sn;
        return v;
    endfunction

    // Expectation for a cycle spent in IDLE (identical to the reset values).
    function automatic vec_t idle(input logic rst_n, input int unsigned l,
                                  input logic [1:0] iren, dren, dwen, cct, ccw);
        return mk(rst_n, l, iren, dren, dwen, cct, ccw, 2'b11, 2'b11, 2'b00, 2'b00,
                  1'b0, 1'b0, 32'h0, 32'h0, Z, Z, Z);
    endfunction

    task automatic chk(input string tag, input string fld, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s %s: got %h, expected %h", tag, fld, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check settled outputs, advance to the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        nRST = v.rst_n; lat = v.lat;
        iREN = v.iren; dREN = v.dren; dWEN = v.dwen; cctrans = v.cct; ccwrite = v.ccw;
        #1;
        n_vec++;
        chk(tag, "iwait",    64'(iwait),       64'(v.e_iwait));
        chk(tag, "dwait",    64'(dwait),       64'(v.e_dwait));
        chk(tag, "ccwait",   64'(ccwait),      64'(v.e_ccwait));
        chk(tag, "ccinv",    64'(ccinv),       64'(v.e_ccinv));
        chk(tag, "ramREN",   64'(ramREN),      64'(v.e_ren));
        chk(tag, "ramWEN",   64'(ramWEN),      64'(v.e_wen));
        chk(tag, "ramaddr",  64'(ramaddr),     64'(v.e_raddr));
        chk(tag, "ramstore", 64'(ramstore),    64'(v.e_rstore));
        chk(tag, "iload",    64'(iload),       v.e_iload);
        chk(tag, "dload",    64'(dload),       v.e_dload);
        chk(tag, "snoopadr", 64'(ccsnoopaddr), v.e_snoop);
        @(negedge CLK);
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] idx, input logic [31:0] exp);
        n_vec++;
        chk(tag, "mem", 64'(mem[idx]), 64'(exp));
    endtask

    vec_t tbl[$];

    initial begin
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr[0] = 32'h0;   iaddr[1] = 32'h40;
        daddr[0] = 32'h100; daddr[1] = 32'h0;
        dstore = '0;

        // Reset, two-core icache round robin (latency 2), then a RAM-served fill for core 0 (latency 0).
        tbl.push_back(idle(1'b0, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(idle(1'b1, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(idle(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, Z, Z, Z));
        tbl.push_back(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, Z, Z, Z));
        tbl.push_back(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, {32'h0, 32'hA000_0000}, Z, Z));
        tbl.push_back(idle(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0, Z, Z, Z));
        tbl.push_back(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0, Z, Z, Z));
        tbl.push_back(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0, {32'hA000_0040, 32'h0}, Z, Z));
        tbl.push_back(idle(1'b1, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(idle(1'b1, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(1'b1, 0, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, Z, Z, {32'h100, 32'h0}));
        tbl.push_back(mk(1'b1, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, Z, {32'h0, 32'hA000_0100}, {32'h100, 32'h0}));
        tbl.push_back(mk(1'b1, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h104, 32'h0, Z, {32'h0, 32'hA000_0104}, {32'h100, 32'h0}));
        tbl.push_back(idle(1'b1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        @(negedge CLK);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // Core 1 BusRdX 0x200 with a late ack; core 0 supplies the Modified block (RAM latency 1).
        daddr[1] = 32'h200;
        apply(idle(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10), "c2c_idle");
        apply(mk(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, Z, Z, {32'h0, 32'h200}), "c2c_snoop_wait");
        dstore[0] = 32'hDEAD;
        apply(mk(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, Z, Z, {32'h0, 32'h200}), "c2c_snoop_ack");
        apply(mk(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1, 32'h200, 32'hDEAD, Z, Z, {32'h0, 32'h200}), "c2c1_busy");
        apply(mk(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 32'h200, 32'hDEAD, Z, {32'hDEAD, 32'h0}, {32'h0, 32'h200}), "c2c1_acc");
        dstore[0] = 32'hBEEF;
        apply(mk(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1, 32'h204, 32'hBEEF, Z, Z, {32'h0, 32'h200}), "c2c2_busy");
        apply(mk(1'b1, 1, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 32'h204, 32'hBEEF, Z, {32'hBEEF, 32'h0}, {32'h0, 32'h200}), "c2c2_acc");
        apply(idle(1'b1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "c2c_done");
        chk_mem("c2c_mem0", 8'h80, 32'hDEAD);
        chk_mem("c2c_mem1", 8'h81, 32'hBEEF);

        // Core 0 dWEN beats core 1 iREN; then core 1 fetch, then a lone core 0 fetch.
        daddr[0] = 32'h300; dstore[0] = 32'h1234_5678;
        apply(idle(1'b1, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00), "wr_idle");
        apply(mk(1'b1, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h1234_5678, Z, Z, Z), "wr_dwrite");
        apply(idle(1'b1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00), "wr_idle2");
        apply(mk(1'b1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0, {32'hA000_0040, 32'h0}, Z, Z), "wr_ifetch1");
        apply(idle(1'b1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), "if0_idle");
        apply(mk(1'b1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, {32'h0, 32'hA000_0000}, Z, Z), "if0_fetch");
        chk_mem("wr_mem", 8'hC0, 32'h1234_5678);

        // Core 1 fill of 0x180 (latency 2), reset asserted in RAMRD2, then tie goes to core 0 again.
        daddr[1] = 32'h180;
        apply(idle(1'b1, 2, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00), "rst_idle");
        apply(mk(1'b1, 2, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, Z, Z, {32'h0, 32'h180}), "rst_snoop");
        apply(mk(1'b1, 2, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h180, 32'h0, Z, Z, {32'h0, 32'h180}), "rst_rd1_b0");
        apply(mk(1'b1, 2, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h180, 32'h0, Z, Z, {32'h0, 32'h180}), "rst_rd1_b1");
        apply(mk(1'b1, 2, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h180, 32'h0, Z, {32'hA000_0180, 32'h0}, {32'h0, 32'h180}), "rst_rd1_acc");
        apply(mk(1'b1, 2, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h184, 32'h0, Z, Z, {32'h0, 32'h180}), "rst_rd2_busy");
        apply(idle(1'b0, 2, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00), "rst_mid_rd2");
        apply(idle(1'b1, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "rst_release");
        apply(idle(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00), "rst_tie_idle");
        apply(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, Z, Z, Z), "rst_tie_core0");
        apply(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, Z, Z, Z), "rst_tie_busy");
        apply(mk(1'b1, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, {32'h0, 32'hA000_0000}, Z, Z), "rst_tie_acc");
        apply(idle(1'b1, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "end_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/coherence_controller.md
# coherence_controller

Shared-memory bus controller for the dual-core build. Arbitrates the single RAM port between two cores' icache and dcache request ports. Sequences MSI snoops so that a dcache miss is served cache-to-cache when the other core holds the block Modified. It sits between both cores' cache pairs and the RAM model, replacing per-core direct RAM access.

## Interface
Parameters:
- CPUS, 2: number of cores; only 2 is supported.
- WORD_W, 32: data and address width.

Ports (per-core signals are [CPUS-1:0] arrays of WORD_W or 1 bit):
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  2  icache read request.
- iaddr  in  2×32  icache word address.
- iwait  out  2  icache stall; low for exactly the cycle iload is valid.
- iload  out  2×32  instruction word.
- dREN  in  2  dcache read (block-fill word).
- dWEN  in  2  dcache write (write-back / flush word).
- daddr  in  2×32  dcache word address.
- dstore  in  2×32  dcache write data, or snoop-response data.
- dwait  out  2  dcache stall; low for the cycle of completion.
- dload  out  2×32  dcache fill data.
- cctrans  in  2  requester: miss transaction in progress. Responder: snoop acknowledge.
- ccwrite  in  2  requester: intent to modify (BusRdX). Responder: block is Modified, data on dstore.
- ccwait  out  2  snoop in progress against this core.
- ccinv  out  2  invalidate the snooped block.
- ccsnoopaddr  out  2×32  address being snooped.
- ramREN, ramWEN  out  1  RAM read/write strobes.
- ramaddr, ramstore  out  32  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- States: IDLE, IFETCH, DWRITE, SNOOP, RAMRD1, RAMRD2, C2C1, C2C2.
- Priority, highest first: dWEN, dREN (cctrans high), iREN. Within a class, round-robin on a `last` pointer. The grant goes to the core ≠ last, else to the sole requester. `last` updates on each completed dcache transaction and on each completed IFETCH.
- IDLE selects the requester and latches `cur` (core index) and the address.
- IDLE→DWRITE for a dWEN grant. The controller forwards daddr/dstore to RAM with ramWEN=1. On ramstate==ACCESS: dwait[cur]=0, then →IDLE. Each write-back word is one DWRITE transaction.
- IDLE→SNOOP for a dREN grant:
  - SNOOP drives ccwait[oth]=1, ccsnoopaddr[oth]=daddr[cur], ccinv[oth]=ccwrite[cur].
  - It stays in SNOOP until cctrans[oth]=1.
  - If ccwrite[oth]=1, →C2C1; otherwise →RAMRD1.
- RAMRD1/RAMRD2 fetch word 0 (daddr[31:3],3'b000) and word 1 (…,3'b100).
  - ramREN=1.
  - On ACCESS: dload[cur]=ramload and dwait[cur]=0 for that cycle. RAMRD1→RAMRD2, RAMRD2→IDLE.
- C2C1/C2C2 move the same two words:
  - dload[cur]=dstore[oth], and the same word is written to RAM (ramWEN=1, ramstore=dstore[oth]).
  - dwait[cur] and dwait[oth] go low together on ACCESS.
  - ccwait[oth] stays high through C2C2.
  - After C2C2, →IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[cur]. On ACCESS: iwait[cur]=0, iload[cur]=ramload, then →IDLE.
- ccwait[oth] is held from SNOOP entry until the transaction's final ACCESS cycle, inclusive.
- Deasserting a request mid-transaction is illegal and undefined. cur and the address are held by latch.
- ramstate BUSY or ERROR: hold the state with all outputs stable.
- Reset values: state=IDLE, last=1 (core 0 wins the first tie), cur=0, iwait=dwait=2'b11, ccwait=ccinv=0, ram strobes=0, all address/data outputs=0.
- Reset mid-transaction: return immediately to IDLE with the reset values. A partially filled block stays invalid in the dcache because it has not seen LD2 complete.

## Timing
- The arbitration decision is registered: there is 1 cycle in IDLE before any RAM strobe.
- Outputs are Moore on state, except the wait/load outputs, which are combinational on ramstate==ACCESS.
- With a 0-latency RAM (ACCESS on first strobe cycle):
  - IFETCH: 2 cycles request→iwait low.
  - RAM fill: 4 cycles to word 1 (IDLE, SNOOP with same-cycle ack, RAMRD1, RAMRD2).
- The snoop response is sampled each SNOOP cycle. There is no timeout.

## Structure
- Add to cpu_types_pkg:
  - ramstate_t.
  - cc_state_t (enum above, logic [2:0]).
  - Constants BLK_W0_OFF=3'b000 and BLK_W1_OFF=3'b100.
- One sub-module, rr_arbiter: a 2-requester round-robin with a registered `last` pointer. It is instantiated once per priority class, or once with a class-mux in front. Target 200–300 lines total.

## Test plan
- Reset: hold nRST=0 → iwait=dwait=2'b11, ccwait=0, ramREN=ramWEN=0. Release, with no requests → stays IDLE.
- Both icaches request (iaddr 0x0 and 0x40), RAM latency 2 → core 0 served first. Then core 1; iload[1]=mem[0x40].
- Core 0 dREN 0x100 with cctrans=1, ccwrite=0; core 1 acks with ccwrite=0:
  - ccsnoopaddr[1]=0x100 and ccinv[1]=0.
  - dload[0]=mem[0x100], then mem[0x104].
- Core 1 BusRdX 0x200 (ccwrite=1); core 0 holds it Modified (dstore 0xDEAD, 0xBEEF):
  - ccinv[0]=1.
  - dload[1]=0xDEAD/0xBEEF.
  - RAM 0x200/0x204 is updated.
  - Both dwait lines drop together.
- Simultaneous dWEN (core 0) and iREN (core 1) → DWRITE first, then IFETCH. Assert nRST mid-RAMRD2 → outputs return to reset values within the same cycle.
